// File: rtl/cloclz_share_ctrl_pkg.sv
// Shared execute-stage constants for the CLO/CLZ unit: operation encodings
// and issue-slot identifiers carried on the response.
package cloclz_share_ctrl_pkg;

  localparam logic OP_CLO = 1'b0;
  localparam logic OP_CLZ = 1'b1;

  localparam logic SLOT0 = 1'b0;
  localparam logic SLOT1 = 1'b1;

  localparam int CNT_W = 6;  // counts 0..32

endpackage

// File: rtl/cloclz_cnt.sv
// Combinational leading-ones / leading-zeros counter on a 32-bit operand.
// CLO is computed as CLZ of the inverted operand so one scan serves both ops.
module cloclz_cnt
  import cloclz_share_ctrl_pkg::*;
(
  input  logic [31:0]      src_i,
  input  logic             op_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [31:0] scan;
  logic        found;

  // NOTE: every variable gets a value before the loop, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    scan  = (op_i == OP_CLO) ? ~src_i : src_i;
    cnt_o = CNT_W'(32);
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && scan[i]) begin
        cnt_o = CNT_W'(31 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cloclz_share_ctrl.sv
// Shares one CLO/CLZ counter between two issue slots: round-robin request
// arbitration feeding a single registered response stage with backpressure.
module cloclz_share_ctrl
  import cloclz_share_ctrl_pkg::*;
#(
  parameter int   TAG_W   = 4,
  parameter logic RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_src,
  input  logic             req0_type,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_src,
  input  logic             req1_type,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [CNT_W-1:0] rsp_cnt_q, rsp_cnt_d;
  logic             rsp_id_q, rsp_id_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rr_ptr_q, rr_ptr_d;

  logic             accept, grant0, grant1, grant;
  logic             sel_slot, sel_type;
  logic [31:0]      sel_src;
  logic [TAG_W-1:0] sel_tag;
  logic [CNT_W-1:0] cnt;

  cloclz_cnt u_cnt (
    .src_i (sel_src),
    .op_i  (sel_type),
    .cnt_o (cnt)
  );

  always_comb begin
    // Readys are held low during reset even though the response stage is empty.
    accept = resetn & ~flush & (~rsp_valid_q | rsp_ready);
    grant0 = accept & req0_valid & (~req1_valid | (rr_ptr_q == SLOT0));
    grant1 = accept & req1_valid & (~req0_valid | (rr_ptr_q == SLOT1));
    grant  = grant0 | grant1;

    sel_slot = grant1 ? SLOT1 : SLOT0;
    sel_src  = grant1 ? req1_src  : req0_src;
    sel_type = grant1 ? req1_type : req0_type;
    sel_tag  = grant1 ? req1_tag  : req0_tag;

    rsp_valid_d = rsp_valid_q;
    rsp_cnt_d   = rsp_cnt_q;
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    rr_ptr_d    = rr_ptr_q;

    if (grant) begin
      rsp_valid_d = 1'b1;
      rsp_cnt_d   = cnt;
      rsp_id_d    = sel_slot;
      rsp_tag_d   = sel_tag;
      rr_ptr_d    = ~sel_slot;
    end else if (flush | rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      rsp_cnt_q   <= '0;
      rsp_id_q    <= SLOT0;
      rsp_tag_q   <= '0;
      rr_ptr_q    <= RR_INIT;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_cnt_q   <= rsp_cnt_d;
      rsp_id_q    <= rsp_id_d;
      rsp_tag_q   <= rsp_tag_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = {{(32 - CNT_W){1'b0}}, rsp_cnt_q};
  assign rsp_id     = rsp_id_q;
  assign rsp_tag    = rsp_tag_q;

endmodule
